// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants used by the fetch stage and the later pipeline stages.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, load enable, synchronous clear.
module pipe_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_q, data_d;

    // Clear beats enable so a flush also wins over a stall.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC select, PC write enable, IF/ID register and stall/flush counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic             jump_i,
    input  logic [XLEN-1:0]  jump_target_i,
    output logic [XLEN-1:0]  pc_next_o,
    output logic             pc_write_o,
    output logic [XLEN-1:0]  if_id_pc4_o,
    output logic [XLEN-1:0]  if_id_instr_o,
    output logic             if_id_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned IfIdW = 2 * XLEN + 1;

    logic [XLEN-1:0]  pc4;
    logic             redirect;
    logic [XLEN-1:0]  pc_sel;
    logic [IfIdW-1:0] if_id_d, if_id_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign pc4      = pc_i + PC_STEP;
    assign redirect = branch_taken_i | jump_i;

    // Branch is resolved in EX and so is older than a jump in ID.
    always_comb begin
        pc_sel = pc4;
        if (branch_taken_i) begin
            pc_sel = branch_target_i;
        end else if (jump_i) begin
            pc_sel = jump_target_i;
        end
    end

    assign pc_next_o  = {pc_sel[XLEN-1:2], 2'b00};
    assign pc_write_o = ~stall_i | redirect;

    assign if_id_d = {pc4, instr_i, 1'b1};

    pipe_reg #(
        .Width (IfIdW)
    ) u_if_id (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .en_i   (~stall_i),
        .clr_i  (redirect),
        .d_i    (if_id_d),
        .q_o    (if_id_q)
    );

    assign if_id_pc4_o   = if_id_q[IfIdW-1 -: XLEN];
    assign if_id_instr_o = if_id_q[XLEN:1];
    assign if_id_valid_o = if_id_q[0];

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_i && !redirect && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU, between the program counter and the decode stage. Each cycle it computes the next PC for the program counter from three sources: sequential PC+4, the taken-branch target, or the jump target. It drives the program counter's write enable. It owns the IF/ID pipeline register and applies hazard stalls and control-flow flushes to it. Saturating stall and flush counters are provided for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- pc_i  in  32  current PC from the program counter output
- instr_i  in  32  instruction read from instruction memory at pc_i (combinational memory)
- stall_i  in  1  load-use stall request from hazard detection
- branch_taken_i  in  1  branch resolved taken in EX
- branch_target_i  in  32  branch target address
- jump_i  in  1  jump decoded in ID
- jump_target_i  in  32  jump target address
- pc_next_o  out  32  next PC, drives the program counter's pc_in_i
- pc_write_o  out  1  drives the program counter's pc_write
- if_id_pc4_o  out  32  registered PC+4 of the instruction held in IF/ID
- if_id_instr_o  out  32  registered instruction
- if_id_valid_o  out  1  IF/ID holds a real, non-flushed instruction
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles
- flush_cnt_o  out  CNT_W  saturating count of flush cycles

## Operation
- pc4 = pc_i + 4, computed modulo 2^32. 0xFFFFFFFC wraps to 0x00000000.
- redirect = branch_taken_i | jump_i.
- Next-PC priority (combinational):
  - branch_taken_i selects branch_target_i. The branch is the older instruction, so it has top priority.
  - Otherwise jump_i selects jump_target_i.
  - Otherwise pc4 is selected.
- pc_next_o[1:0] is always forced to 2'b00.
- pc_write_o = ~stall_i | redirect. A redirect overrides a stall, because the stalled instruction is younger and is being squashed.
- IF/ID update at each rising edge, in priority order:
  - redirect: flush. Instr becomes NOP (0x00000000), pc4 becomes 0, valid becomes 0.
  - stall_i and no redirect: hold all three fields.
  - Otherwise: capture pc4, instr_i, and valid=1.
- stall_cnt increments on each cycle with stall_i=1 and redirect=0.
- flush_cnt increments on each cycle with redirect=1.
- Both counters saturate at all-ones and never wrap.
- Reset (rst_i=0, takes effect immediately, no clock needed):
  - IF/ID becomes pc4=0, instr=0, valid=0.
  - Both counters become 0.
  - Combinational outputs follow their inputs during reset. The program counter holds itself at 0 under the same reset.
  - A reset asserted mid-stall or mid-flush discards that state. The first edge after deassertion performs a normal capture.

## Timing
- Next-PC path: zero latency. pc_next_o and pc_write_o are combinational from the inputs in the same cycle.
- IF/ID path: one-cycle latency. A fetch in cycle N appears on the if_id_* outputs in cycle N+1.
- Single stall cycle: IF/ID and PC both hold. The same instruction is presented again next cycle.
- Flush: exactly one bubble enters IF/ID per redirect cycle. The target instruction is captured on the following edge.
- Simultaneous branch_taken_i and jump_i: branch target wins, one flush, flush_cnt +1.
- Simultaneous stall_i and redirect: flush, PC written, stall_cnt unchanged.

## Structure
- Shared CPU package holds:
  - NOP_INSTR = 32'h00000000
  - PC_STEP = 4
  - XLEN = 32
- One sub-module, pipe_reg:
  - Parameterised width, asynchronous active-low reset, enable, synchronous clear-to-zero.
  - Instantiated once for the IF/ID bundle {pc4, instr, valid}.
  - Reused later for ID/EX, EX/MEM and MEM/WB.
- Next-PC mux and counters are written inline in fetch_stage.

## Test plan
- Reset, then pc_i=0x0, instr_i=0x20080005, no hazards, one edge. Expect pc_next_o=0x4, pc_write_o=1, if_id_pc4_o=0x4, if_id_instr_o=0x20080005, if_id_valid_o=1.
- Assert stall_i for 2 cycles with pc_i=0x10. Expect pc_write_o=0, IF/ID held unchanged, stall_cnt_o=2.
- Assert branch_taken_i, branch_target_i=0x40 and stall_i together. Expect pc_next_o=0x40, pc_write_o=1. Next edge: if_id_instr_o=0, if_id_valid_o=0, flush_cnt_o=1, stall_cnt_o unchanged.
- Assert branch_taken_i (target 0x80) with jump_i (target 0x100). Expect pc_next_o=0x80. Apply jump_target_i=0x103 alone and expect pc_next_o=0x100.
- pc_i=0xFFFFFFFC with no hazards. Expect pc_next_o=0x0 and if_id_pc4_o=0x0 after the edge. With CNT_W=4, hold stall_i for 20 cycles and expect stall_cnt_o to stick at 0xF.
- Drop rst_i mid-cycle while IF/ID is valid. Expect IF/ID and both counters to clear immediately, without waiting for a clock edge.
